// File: rtl/clkdiv_period_meter.sv
// Measures the half-period of an asynchronous square wave in clk cycles and reports it
// as a divider limit (H-1), with lock detection against the previous measurement.
module clkdiv_period_meter #(
  parameter int unsigned BITLEN = 8,
  parameter int unsigned TOL    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  output logic [BITLEN-1:0] lim,
  output logic              valid,
  output logic              locked,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    OVF
  } state_t;

  localparam logic [BITLEN-1:0] CNT_MAX = '1;
  localparam logic [BITLEN:0]   TOL_V   = (BITLEN+1)'(TOL);

  state_t            state, state_nx;
  logic              s1, s2, s3;
  logic              sig_edge;
  logic [BITLEN-1:0] cnt, cnt_nx;
  logic [BITLEN-1:0] prev, prev_nx;
  logic              have_prev, have_prev_nx;
  logic [BITLEN-1:0] lim_nx;
  logic              valid_nx, locked_nx, ovf_nx;
  logic              cnt_max;
  logic [BITLEN:0]   diff;
  logic              within_tol;

  assign sig_edge = s2 ^ s3;
  assign cnt_max  = (cnt == CNT_MAX);

  always_comb begin
    if (cnt >= prev) diff = {1'b0, cnt} - {1'b0, prev};
    else             diff = {1'b0, prev} - {1'b0, cnt};
  end

  assign within_tol = (diff <= TOL_V);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sig_edge) state_nx = COUNT;
      COUNT:   if (!sig_edge && cnt_max) state_nx = OVF;
      OVF:     if (sig_edge) state_nx = COUNT;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and measurement history.
  always_comb begin
    lim_nx       = lim;
    valid_nx     = 1'b0;
    locked_nx    = locked;
    ovf_nx       = ovf;
    prev_nx      = prev;
    have_prev_nx = have_prev;
    case (state)
      IDLE: begin
        have_prev_nx = 1'b0;
      end
      COUNT: begin
        if (sig_edge) begin
          lim_nx       = cnt;
          valid_nx     = 1'b1;
          prev_nx      = cnt;
          ovf_nx       = 1'b0;
          have_prev_nx = 1'b1;
          locked_nx    = have_prev ? within_tol : 1'b0;
        end else if (cnt_max) begin
          ovf_nx       = 1'b1;
          locked_nx    = 1'b0;
          have_prev_nx = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    if (sig_edge)     cnt_nx = '0;
    else if (cnt_max) cnt_nx = cnt;
    else              cnt_nx = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      prev      <= '0;
      have_prev <= 1'b0;
      lim       <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      s1        <= sig_in;
      s2        <= s1;
      s3        <= s2;
      cnt       <= cnt_nx;
      prev      <= prev_nx;
      have_prev <= have_prev_nx;
      lim       <= lim_nx;
      valid     <= valid_nx;
      locked    <= locked_nx;
      ovf       <= ovf_nx;
    end
  end

endmodule
